mem_ctrl: RTL and testbench

- Sits directly upstream of the instruction fetch stage. It is the single owner of the byte-wide RAM/IO port.
- Services two clients: 64-byte instruction-block reads for the I-cache fill, and 1/2/4-byte loads and stores from the load/store buffer.
- Serialises every access into byte transactions and returns each completed request with a one-cycle done pulse.

---
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO port owner for I-cache block fills and LSB loads/stores
// Optional: define MEMC_IOBUF_STALL_EN to hold IO-mapped store bytes while io_buffer_full is set.
module mem_ctrl #(
  parameter int         IF_BLK_BYTES = 64,
  parameter int         ADDR_W       = 32,
  parameter logic [1:0] IO_ADDR_MARK = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [ADDR_W-1:0]         mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full,
  input  logic                      if_en,
  input  logic [ADDR_W-1:0]         if_pc,
  output logic                      if_done,
  output logic [IF_BLK_BYTES*8-1:0] if_data,
  input  logic                      lsb_en,
  input  logic                      lsb_wr,
  input  logic [ADDR_W-1:0]         lsb_addr,
  input  logic [1:0]                lsb_len,
  input  logic [31:0]               lsb_w_data,
  output logic                      lsb_done,
  output logic [31:0]               lsb_r_data,
  input  logic                      rob_clear
);
  localparam int CW = $clog2(IF_BLK_BYTES + 1);
  localparam int BW = $clog2(IF_BLK_BYTES * 8);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             n;
  logic [ADDR_W-1:0]         base;
  logic [31:0]               wsh;
  logic [IF_BLK_BYTES*8-1:0] blk;
  logic [IF_BLK_BYTES*8-1:0] blk_nx;
  logic [BW-1:0]             bidx;
  logic                      stall_new;
  logic                      stall_cur;

`ifdef MEMC_IOBUF_STALL_EN
  assign stall_new = (lsb_addr[17:16] == IO_ADDR_MARK) && io_buffer_full;
  assign stall_cur = (base[17:16] == IO_ADDR_MARK) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign stall_new = 1'b0;
  assign stall_cur = 1'b0;
`endif

  // During a read, cnt counts cycles; mem_din in cycle cnt carries byte cnt-1.
  always_comb begin
    bidx   = BW'({cnt - CW'(1), 3'b000});
    blk_nx = blk;
    if (cnt != '0) blk_nx[bidx +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      n          <= '0;
      base       <= '0;
      wsh        <= '0;
      blk        <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
      if_data    <= '0;
      lsb_r_data <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          blk    <= '0;
          mem_wr <= 1'b0;
          // A load under flush is refused, which lets a pending fill go instead.
          if (lsb_en && (lsb_wr || !rob_clear)) begin
            base  <= lsb_addr;
            n     <= CW'(lsb_len) + CW'(1);
            mem_a <= lsb_addr;
            if (lsb_wr) begin
              state    <= LS_WR;
              mem_dout <= lsb_w_data[7:0];
              wsh      <= lsb_w_data >> 8;
              mem_wr   <= !stall_new;
            end else begin
              state <= LS_RD;
            end
          end else if (if_en) begin
            base  <= if_pc;
            n     <= CW'(IF_BLK_BYTES);
            mem_a <= if_pc;
            state <= IF_RD;
          end
        end
        IF_RD, LS_RD: begin
          if (state == LS_RD && rob_clear) begin
            state <= IDLE;
          end else begin
            blk <= blk_nx;
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) < n) mem_a <= base + ADDR_W'(cnt) + ADDR_W'(1);
            if (cnt == n) begin
              state <= DONE;
              if (state == IF_RD) begin
                if_done <= 1'b1;
                if_data <= blk_nx;
              end else begin
                lsb_done   <= 1'b1;
                lsb_r_data <= blk_nx[31:0];
              end
            end
          end
        end
        LS_WR: begin
          if (!mem_wr) begin
            mem_wr <= !stall_cur;
          end else if (cnt + CW'(1) < n) begin
            cnt      <= cnt + CW'(1);
            mem_a    <= base + ADDR_W'(cnt) + ADDR_W'(1);
            mem_dout <= wsh[7:0];
            wsh      <= wsh >> 8;
            mem_wr   <= !stall_cur;
          end else begin
            mem_wr   <= 1'b0;
            lsb_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl: vector table, corner sequences, random vs reference model
module tb_mem_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic [7:0]   mem_din = '0;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full = 1'b0;
  logic         if_en = 1'b0;
  logic [31:0]  if_pc = '0;
  logic         if_done;
  logic [511:0] if_data;
  logic         lsb_en = 1'b0;
  logic         lsb_wr = 1'b0;
  logic [31:0]  lsb_addr = '0;
  logic [1:0]   lsb_len = '0;
  logic [31:0]  lsb_w_data = '0;
  logic         lsb_done;
  logic [31:0]  lsb_r_data;
  logic         rob_clear = 1'b0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .rob_clear(rob_clear)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:262143];
  logic [7:0] mdl [0:262143];

  // Byte RAM with one-cycle read latency; stalls together with the rest of the system on rdy.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] len);
    logic [31:0] r = '0;
    for (int i = 0; i < int'(len) + 1; i++) r |= 32'(mdl[a[17:0] + 18'(i)]) << (8 * i);
    return r;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    for (int i = 0; i < int'(len) + 1; i++) mdl[a[17:0] + 18'(i)] = d[8*i +: 8];
  endfunction

  function automatic int ref_lat(input int kind, input logic [1:0] len);
    if (kind == 2) return 65;
    if (kind == 0) return int'(len) + 2;
    return int'(len) + 1;
  endfunction

  function automatic int blk_mismatch(input logic [31:0] a);
    int m = 0;
    for (int k = 0; k < 64; k++) if (if_data[8*k +: 8] !== mdl[a[17:0] + 18'(k)]) m++;
    return m;
  endfunction

  // kind: 0 = load, 1 = store, 2 = fill; lat counts cycles from the accepting edge to done.
  task automatic run_req(input int kind, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wd, output int lat);
    if (kind == 2) begin
      if_en = 1'b1; if_pc = addr;
    end else begin
      lsb_en = 1'b1; lsb_wr = (kind == 1); lsb_addr = addr; lsb_len = len; lsb_w_data = wd;
    end
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if ((kind == 2) ? if_done : lsb_done) begin lat = k - 1; break; end
    end
    if_en = 1'b0; lsb_en = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat, cnt_a, cnt_b, at_a, at_b;
    logic [31:0] a, d;
    logic [1:0] ln;
    int kind;

    for (int i = 0; i < 262144; i++) begin
      ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      mdl[i] = ram[i];
    end
    for (int k = 0; k < 64; k++) begin ram[18'h40 + 18'(k)] = 8'(k); mdl[18'h40 + 18'(k)] = 8'(k); end
    ram[18'h100] = 8'hEF; ram[18'h101] = 8'hBE; ram[18'h102] = 8'hAD; ram[18'h103] = 8'hDE;
    mdl[18'h100] = 8'hEF; mdl[18'h101] = 8'hBE; mdl[18'h102] = 8'hAD; mdl[18'h103] = 8'hDE;

    tbl[0] = '{0, 32'h100, 2'd3, 32'h0,        32'hDEADBEEF, 5};
    tbl[1] = '{0, 32'h100, 2'd0, 32'h0,        32'h000000EF, 2};
    tbl[2] = '{0, 32'h101, 2'd1, 32'h0,        32'h0000ADBE, 3};
    tbl[3] = '{1, 32'h300, 2'd3, 32'hCAFEF00D, 32'h0,        4};
    tbl[4] = '{0, 32'h300, 2'd3, 32'h0,        32'hCAFEF00D, 5};
    tbl[5] = '{1, 32'h302, 2'd0, 32'h00000077, 32'h0,        1};
    tbl[6] = '{0, 32'h300, 2'd3, 32'h0,        32'hCA77F00D, 5};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset mem_wr", 64'(mem_wr), 0);
    check("reset mem_a", 64'(mem_a), 0);
    check("reset mem_dout", 64'(mem_dout), 0);
    check("reset dones", {62'd0, if_done, lsb_done}, 0);
    check("reset if_data", 64'(if_data != '0), 0);
    check("reset lsb_r_data", 64'(lsb_r_data), 0);

    run_req(2, 32'h40, 2'd0, 32'h0, lat);
    check("fill latency", 64'(lat), 65);
    check("fill byte0", 64'(if_data[7:0]), 64'h00);
    check("fill byte63", 64'(if_data[511:504]), 64'h3F);
    check("fill block", 64'(blk_mismatch(32'h40)), 0);

    for (int i = 0; i < 7; i++) begin
      run_req(tbl[i].kind, tbl[i].addr, tbl[i].len, tbl[i].wd, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      if (tbl[i].kind == 0) check($sformatf("vec%0d data", i), 64'(lsb_r_data), 64'(tbl[i].exp_rd));
      if (tbl[i].kind == 1) ref_store(tbl[i].addr, tbl[i].len, tbl[i].wd);
    end
    check("if_data held", 64'(if_data[511:504]), 64'h3F);

    // Half store, cycle by cycle.
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h200; lsb_len = 2'd1; lsb_w_data = 32'h1234;
    @(posedge clk); #1;
    check("hs c0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h200, 8'h34});
    @(posedge clk); #1;
    check("hs c1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h201, 8'h12});
    @(posedge clk); #1;
    check("hs c2 done", {lsb_done, mem_wr}, 2'b10);
    lsb_en = 1'b0;
    @(posedge clk); #1;
    check("hs idle mem_wr", 64'(mem_wr), 0);
    ref_store(32'h200, 2'd1, 32'h1234);
    check("hs stored", 64'(ram[18'h200] | (16'(ram[18'h201]) << 8)), 64'h1234);

    // Arbitration: load and fill requested together.
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 2'd3; if_en = 1'b1; if_pc = 32'h80;
    cnt_a = 0; at_a = -1; at_b = -1;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if (lsb_done) begin cnt_a++; at_a = k; lsb_en = 1'b0; end
      if (if_done) begin at_b = k; if_en = 1'b0; break; end
    end
    @(posedge clk); #1;
    check("arb lsb edge", 64'(at_a), 6);
    check("arb lsb pulses", 64'(cnt_a), 1);
    check("arb lsb data", 64'(lsb_r_data), 64'hDEADBEEF);
    check("arb fill edge", 64'(at_b), 73);
    check("arb fill block", 64'(blk_mismatch(32'h80)), 0);

    // Flush on cycle 2 and on the final-capture cycle of a word load.
    for (int t = 0; t < 2; t++) begin
      lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 2'd3;
      repeat (t == 0 ? 3 : 5) @(posedge clk);
      #1 rob_clear = 1'b1;
      @(posedge clk); #1;
      rob_clear = 1'b0; lsb_en = 1'b0;
      check($sformatf("flush%0d no done", t), 64'(lsb_done), 0);
      run_req(0, 32'h300, 2'd3, 32'h0, lat);
      check($sformatf("flush%0d idle next", t), 64'(lat), 5);
      check($sformatf("flush%0d reload", t), 64'(lsb_r_data), 64'(ref_load(32'h300, 2'd3)));
    end

    // Under flush: load refused, store and fill proceed.
    rob_clear = 1'b1;
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 2'd3;
    cnt_b = 0;
    repeat (8) begin @(posedge clk); #1; if (lsb_done) cnt_b++; end
    lsb_en = 1'b0;
    check("flush load refused", 64'(cnt_b), 0);
    run_req(1, 32'h400, 2'd3, 32'hA5A55A5A, lat);
    ref_store(32'h400, 2'd3, 32'hA5A55A5A);
    check("flush store latency", 64'(lat), 4);
    run_req(2, 32'hC0, 2'd0, 32'h0, lat);
    check("flush fill latency", 64'(lat), 65);
    rob_clear = 1'b0;
    run_req(0, 32'h400, 2'd3, 32'h0, lat);
    check("flush store data", 64'(lsb_r_data), 64'hA5A55A5A);

    // rdy low for three edges mid-load.
    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 2'd3;
    at_a = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 2) rdy = 1'b0;
      if (k == 5) rdy = 1'b1;
      if (lsb_done && rdy) begin at_a = k - 1; break; end
    end
    lsb_en = 1'b0;
    @(posedge clk); #1;
    check("rdy latency", 64'(at_a), 8);
    check("rdy data", 64'(lsb_r_data), 64'hDEADBEEF);

    // Reset in the middle of a store.
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h500; lsb_len = 2'd3; lsb_w_data = 32'h11223344;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst outputs", {mem_wr, lsb_done, mem_a}, 34'd0);
    rst = 1'b0; lsb_en = 1'b0;
    ref_store(32'h500, 2'd1, 32'h3344);
    @(posedge clk); #1;
    check("midrst no done", 64'(lsb_done), 0);

`ifdef MEMC_IOBUF_STALL_EN
    io_buffer_full = 1'b1;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 2'd0; lsb_w_data = 32'h5A;
    cnt_a = 0; at_a = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) io_buffer_full = 1'b0;
      if (k <= 3 && mem_wr) cnt_a++;
      if (k == 4) check("io issue", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h5A});
      if (lsb_done) begin at_a = k; break; end
    end
    lsb_en = 1'b0;
    @(posedge clk); #1;
    check("io stalled writes", 64'(cnt_a), 0);
    check("io done edge", 64'(at_a), 5);
    ref_store(32'h30000, 2'd0, 32'h5A);
`else
    io_buffer_full = 1'b1;
    run_req(1, 32'h30000, 2'd0, 32'h5A, lat);
    io_buffer_full = 1'b0;
    check("io ignored latency", 64'(lat), 1);
    ref_store(32'h30000, 2'd0, 32'h5A);
`endif
    check("io byte", 64'(ram[18'h30000]), 64'h5A);

    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 2));
      ln = (kind == 2) ? 2'd0 : 2'($urandom_range(0, 2));
      if (ln == 2'd2) ln = 2'd3;
      a = 32'($urandom_range(0, 32'hFFF0));
      if (kind == 2) a = a & ~32'h3F;
      d = $urandom;
      run_req(kind, a, ln, d, lat);
      check($sformatf("rnd%0d latency", r), 64'(lat), 64'(ref_lat(kind, ln)));
      if (kind == 0) check($sformatf("rnd%0d load", r), 64'(lsb_r_data), 64'(ref_load(a, ln)));
      if (kind == 1) ref_store(a, ln, d);
      if (kind == 2) check($sformatf("rnd%0d fill", r), 64'(blk_mismatch(a)), 0);
    end

    cnt_a = 0;
    for (int i = 0; i < 262144; i++) if (ram[i] !== mdl[i]) cnt_a++;
    check("ram image", 64'(cnt_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
